// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned FWD_RF  = 0;
    localparam int unsigned FWD_OFS = 1;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             is_load;
    } entry_t;

    // Forward-select width: one code per tracker entry plus the register-file code.
    function automatic int unsigned sel_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Decode-side bundle between the decode stage and the hazard controller.
interface hazard_if
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned WB_DEPTH = 3
);
    localparam int unsigned SEL_W = sel_w(WB_DEPTH);

    logic                     id_valid;
    logic [REG_W*NUM_SRC-1:0] id_rs;
    logic [NUM_SRC-1:0]       id_rs_used;
    logic [REG_W-1:0]         id_rd;
    logic                     id_regwrite;
    logic                     id_is_load;
    logic                     ex_branch_taken;
    logic                     stall;
    logic                     flush;
    logic [SEL_W*NUM_SRC-1:0] fwd_sel;
    logic [REG_W-1:0]         wb_rd;
    logic                     wb_we;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_load, ex_branch_taken,
        input  stall, flush, fwd_sel, wb_rd, wb_we
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_is_load, ex_branch_taken,
        output stall, flush, fwd_sel, wb_rd, wb_we
    );

endinterface

// File: rtl/hazard_match.sv
// Matches one source operand against every tracker entry; youngest match wins.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned WB_DEPTH   = 3,
    parameter int unsigned LOAD_READY = 1
) (
    input  logic [REG_W-1:0]              i_rs,
    input  logic                          i_used,
    input  entry_t [WB_DEPTH-1:0]         i_entries,
    output logic [sel_w(WB_DEPTH)-1:0]    o_sel_c,
    output logic                          o_load_hit_c
);
    localparam int unsigned SEL_W = sel_w(WB_DEPTH);

    // Scan oldest to youngest so the lowest index overwrites older hits.
    always_comb begin
        o_sel_c      = SEL_W'(FWD_RF);
        o_load_hit_c = 1'b0;
        for (int k = int'(WB_DEPTH) - 1; k >= 0; k--) begin
            if (i_used && (i_rs != '0) && i_entries[k].valid && i_entries[k].we &&
                (i_entries[k].rd == i_rs)) begin
                o_sel_c      = SEL_W'(k + int'(FWD_OFS));
                o_load_hit_c = i_entries[k].is_load && (k < int'(LOAD_READY));
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use interlock, branch-shadow flush.
// Optional feature macro: LOAD_USE_STALL_EN enables the load-use interlock.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned WB_DEPTH    = 3,
    parameter int unsigned LOAD_READY  = 1,
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  bus
);
    localparam int unsigned SEL_W = sel_w(WB_DEPTH);
    localparam int unsigned CNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
`ifdef LOAD_USE_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    entry_t [WB_DEPTH-1:0]    r_trk;
    logic [CNT_W-1:0]         r_flush_cnt;
    logic [CNT_W-1:0]         w_flush_cnt_nxt;
    logic                     w_accept;
    logic                     w_flush;
    logic                     w_stall;
    logic [NUM_SRC-1:0]       w_load_hit;
    logic [SEL_W*NUM_SRC-1:0] w_fwd_sel;

    for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_src
        hazard_match #(
            .WB_DEPTH   (WB_DEPTH),
            .LOAD_READY (LOAD_READY)
        ) u_match (
            .i_rs         (bus.id_rs[REG_W*g +: REG_W]),
            .i_used       (bus.id_rs_used[g]),
            .i_entries    (r_trk),
            .o_sel_c      (w_fwd_sel[SEL_W*g +: SEL_W]),
            .o_load_hit_c (w_load_hit[g])
        );
    end

    // Branch-shadow counter next state and the interlock decision.
    always_comb begin
        w_flush_cnt_nxt = r_flush_cnt;
        w_accept        = bus.ex_branch_taken && (r_flush_cnt == '0);
        w_flush         = w_accept || (r_flush_cnt != '0);
        if (w_accept) begin
            w_flush_cnt_nxt = CNT_W'(FLUSH_DEPTH - 1);
        end else if (r_flush_cnt != '0) begin
            w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
        end
        w_stall = STALL_EN && bus.id_valid && (|w_load_hit) && !w_flush;
    end

    // Tracker shifts every cycle; stall or flush injects a bubble at EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt <= '0;
            r_trk       <= '0;
        end else begin
            r_flush_cnt <= w_flush_cnt_nxt;
            for (int k = int'(WB_DEPTH) - 1; k > 0; k--) begin
                r_trk[k] <= r_trk[k-1];
            end
            r_trk[0] <= '{valid:   bus.id_valid && !w_flush && !w_stall,
                          rd:      bus.id_rd,
                          we:      bus.id_regwrite,
                          is_load: bus.id_is_load};
        end
    end

    assign bus.stall   = w_stall;
    assign bus.flush   = w_flush;
    assign bus.fwd_sel = w_fwd_sel;
    assign bus.wb_rd   = r_trk[WB_DEPTH-1].rd;
    assign bus.wb_we   = r_trk[WB_DEPTH-1].valid && r_trk[WB_DEPTH-1].we &&
                         (r_trk[WB_DEPTH-1].rd != '0);

endmodule
